// File: rtl/mau_pkg.sv
// mau_pkg: shared constants for the memory access unit.
// RV32I funct3 width/sign codes and FSM state encodings.
package mau_pkg;

  // Load codes
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  // Store codes (share encodings with the signed loads)
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // FSM states
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUS  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

endpackage

// File: rtl/mau_lane_align.sv
// mau_lane_align: combinational byte-lane logic for the memory access unit.
// Request side: legality check, store strobes and lane replication.
// Response side: load byte/half select with sign or zero extension.
module mau_lane_align
  import mau_pkg::*;
(
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [1:0]  req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_legal,
  output logic [3:0]  req_wstrb,
  output logic [31:0] req_wdata_rep,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_addr,
  input  logic [31:0] ld_raw,
  output logic [31:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Legality: alignment per width, reserved codes, unsigned codes are load-only
  always_comb begin
    req_legal = 1'b0;
    case (req_funct3)
      F3_LB:   req_legal = 1'b1;
      F3_LH:   req_legal = ~req_addr[0];
      F3_LW:   req_legal = (req_addr == 2'b00);
      F3_LBU:  req_legal = ~req_we;
      F3_LHU:  req_legal = ~req_we & ~req_addr[0];
      default: req_legal = 1'b0;
    endcase
  end

  // Store strobes and lane replication; loads carry no strobes
  always_comb begin
    req_wstrb     = 4'b0000;
    req_wdata_rep = req_wdata;
    if (req_we) begin
      case (req_funct3[1:0])
        2'b00: begin
          req_wstrb     = 4'b0001 << req_addr;
          req_wdata_rep = {4{req_wdata[7:0]}};
        end
        2'b01: begin
          req_wstrb     = 4'b0011 << {req_addr[1], 1'b0};
          req_wdata_rep = {2{req_wdata[15:0]}};
        end
        default: req_wstrb = 4'hF;
      endcase
    end
  end

  assign ld_byte = ld_raw[{ld_addr, 3'b000} +: 8];
  assign ld_half = ld_raw[{ld_addr[1], 4'b0000} +: 16];

  // Load extract and extend
  always_comb begin
    ld_data = ld_raw;
    case (ld_funct3)
      F3_LB:   ld_data = {{24{ld_byte[7]}}, ld_byte};
      F3_LH:   ld_data = {{16{ld_half[15]}}, ld_half};
      F3_LBU:  ld_data = {24'h0, ld_byte};
      F3_LHU:  ld_data = {16'h0, ld_half};
      default: ld_data = ld_raw;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store unit between MEM stage and a valid/ready data bus.
// FSM IDLE->BUS->DONE->IDLE, one bus transaction per accepted request.
// Optional bus timeout abort enabled by defining MAU_TIMEOUT_EN.
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        ex_req_valid,
  input  logic        ex_we,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_wdata,
  output logic        cpu_stall,
  output logic        cpu_rvalid,
  output logic [31:0] cpu_rdata,
  output logic        cpu_misalign,
  output logic        cpu_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wstrb,
  input  logic        bus_ready,
  input  logic [31:0] bus_rdata
);

  logic [1:0]  state;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic        rvalid_q;
  logic        err_q;
  logic [31:0] rdata_q;

  logic        legal;
  logic [3:0]  wstrb_n;
  logic [31:0] wdata_n;
  logic [31:0] ld_data;
  logic        accept;
  logic        in_bus;
  logic        to_hit;

  mau_lane_align u_align (
    .req_we        (ex_we),
    .req_funct3    (ex_funct3),
    .req_addr      (ex_addr[1:0]),
    .req_wdata     (ex_wdata),
    .req_legal     (legal),
    .req_wstrb     (wstrb_n),
    .req_wdata_rep (wdata_n),
    .ld_funct3     (f3_q),
    .ld_addr       (addr_q[1:0]),
    .ld_raw        (bus_rdata),
    .ld_data       (ld_data)
  );

  // Reset gates the combinational outputs so everything reads 0 under reset
  assign in_bus       = (state == BUS);
  assign accept       = rstn & (state == IDLE) & ex_req_valid & legal;
  assign cpu_misalign = rstn & (state == IDLE) & ex_req_valid & ~legal;
  assign cpu_stall    = accept | in_bus;

  assign bus_req    = in_bus;
  assign bus_we     = we_q;
  assign bus_addr   = {addr_q[31:2], 2'b00};
  assign bus_wdata  = wdata_q;
  assign bus_wstrb  = wstrb_q;
  assign cpu_rvalid = rvalid_q;
  assign cpu_rdata  = rdata_q;
  assign cpu_err    = err_q;

`ifdef MAU_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt;

  // cnt holds completed BUS cycles, so the limit is hit in the last allowed cycle
  assign to_hit = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Saturating BUS-cycle counter, cleared when a request is accepted
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                                       cnt <= '0;
    else if (accept)                                 cnt <= '0;
    else if (in_bus && cnt != CNT_W'(TIMEOUT_CYCLES)) cnt <= cnt + CNT_W'(1);
  end
`else
  assign to_hit = 1'b0;
`endif

  // Main FSM with request latch and registered response
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      we_q     <= 1'b0;
      f3_q     <= 3'b000;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      wstrb_q  <= 4'h0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            we_q    <= ex_we;
            f3_q    <= ex_funct3;
            addr_q  <= ex_addr;
            wdata_q <= wdata_n;
            wstrb_q <= wstrb_n;
            state   <= BUS;
          end
        end
        BUS: begin
          // bus_ready in the limit cycle still completes normally
          if (bus_ready) begin
            rdata_q  <= we_q ? 32'h0 : ld_data;
            rvalid_q <= 1'b1;
            err_q    <= 1'b0;
            state    <= DONE;
          end else if (to_hit) begin
            rdata_q  <= 32'h0;
            rvalid_q <= 1'b1;
            err_q    <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          rvalid_q <= 1'b0;
          err_q    <= 1'b0;
          rdata_q  <= 32'h0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
